// File: rtl/sync_moore_sequence_generator.sv
// sync_moore_sequence_generator: serial frame transmitter (preamble, MSB-first data, idle gap) on a registered line.
// Optional even-parity bit after the data when SEQGEN_PARITY_EN is defined.
module sync_moore_sequence_generator #(
    parameter int          DATA_W   = 8,
    parameter int          PRE_LEN  = 4,
    parameter logic [15:0] PREAMBLE = 16'hA000,
    parameter int          GAP_LEN  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ip_valid,
    input  logic [DATA_W-1:0] ip_data,
    output logic              ip_ready,
    output logic              op,
    output logic              busy,
    output logic              done
);
`ifdef SEQGEN_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int SW   = PRE_LEN + DATA_W + PB;
    localparam int ML   = PRE_LEN > DATA_W ? PRE_LEN : DATA_W;
    localparam int MAXL = ML > GAP_LEN ? ML : GAP_LEN;
    localparam int CW   = $clog2(MAXL + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DATA = 3'd2,
`ifdef SEQGEN_PARITY_EN
        S_PAR  = 3'd3,
`endif
        S_GAP  = 3'd4
    } state_t;

    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [SW-1:0]   r_sh, w_sh, w_frame;
    logic            w_accept, w_last_gap;

    // The whole frame body is loaded at acceptance and shifted out MSB-first; zeros fill in behind it.
`ifdef SEQGEN_PARITY_EN
    assign w_frame = {PREAMBLE[15 -: PRE_LEN], ip_data, ^ip_data};
`else
    assign w_frame = {PREAMBLE[15 -: PRE_LEN], ip_data};
`endif
    assign w_last_gap = r_state == S_GAP && r_cnt == CW'(GAP_LEN - 1);
    // Ready in the last gap cycle lets a held ip_valid restart after exactly GAP_LEN zeros.
    assign ip_ready   = r_state == S_IDLE || w_last_gap;
    assign w_accept   = ip_valid & ip_ready;
    assign op         = r_sh[SW-1];
    assign busy       = r_state != S_IDLE;
    assign done       = r_state == S_GAP && r_cnt == '0;

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt + 1'b1;
        w_sh    = {r_sh[SW-2:0], 1'b0};
        case (r_state)
            S_IDLE: begin
                w_cnt = '0;
                w_sh  = w_accept ? w_frame : '0;
                w_state = w_accept ? S_PRE : S_IDLE;
            end
            S_PRE: if (r_cnt == CW'(PRE_LEN - 1)) begin
                w_state = S_DATA;
                w_cnt   = '0;
            end
            S_DATA: if (r_cnt == CW'(DATA_W - 1)) begin
`ifdef SEQGEN_PARITY_EN
                w_state = S_PAR;
`else
                w_state = S_GAP;
`endif
                w_cnt   = '0;
            end
`ifdef SEQGEN_PARITY_EN
            S_PAR: begin
                w_state = S_GAP;
                w_cnt   = '0;
            end
`endif
            S_GAP: if (w_last_gap) begin
                w_cnt   = '0;
                w_state = w_accept ? S_PRE : S_IDLE;
                w_sh    = w_accept ? w_frame : '0;
            end
            default: begin
                w_state = S_IDLE;
                w_cnt   = '0;
                w_sh    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sh    <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_sh    <= w_sh;
        end
    end
endmodule
